// File: rtl/interrupt_defs.sv
// Shared definitions for the Game Boy interrupt controller: IF bit positions,
// dispatch vectors, the IF register select and the FSM state encodings.
package interrupt_defs;

    localparam int unsigned IRQ_BIT_VBLANK  = 0;
    localparam int unsigned IRQ_BIT_LCDSTAT = 1;
    localparam int unsigned IRQ_BIT_TIMER   = 2;
    localparam int unsigned IRQ_BIT_SERIAL  = 3;
    localparam int unsigned IRQ_BIT_JOYPAD  = 4;

    localparam logic [7:0] VEC_VBLANK  = 8'h40;
    localparam logic [7:0] VEC_LCDSTAT = 8'h48;
    localparam logic [7:0] VEC_TIMER   = 8'h50;
    localparam logic [7:0] VEC_SERIAL  = 8'h58;
    localparam logic [7:0] VEC_JOYPAD  = 8'h60;

    localparam logic [3:0] IF_REG_SEL = 4'hF;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_ACK
    } irqState_t;

    typedef enum logic [1:0] {
        EI_IDLE,
        EI_ARM,
        EI_DELAY
    } eiState_t;

    function automatic logic [7:0] irqVector(input logic [2:0] index);
        case (index)
            3'd0:    return VEC_VBLANK;
            3'd1:    return VEC_LCDSTAT;
            3'd2:    return VEC_TIMER;
            3'd3:    return VEC_SERIAL;
            3'd4:    return VEC_JOYPAD;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_priority_encoder.sv
// Fixed-priority encoder: the lowest set pending bit wins and is turned into
// its index and dispatch vector.
module interrupt_priority_encoder
    import interrupt_defs::*;
(
    input  logic [4:0] pending,
    output logic [2:0] index,
    output logic       valid,
    output logic [7:0] vector
);

    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (pending[i] && !valid) begin
                index = 3'(i);
                valid = 1'b1;
            end
        end
        vector = valid ? irqVector(index) : 8'h00;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: IF/IE registers, IME with delayed EI, and a
// request/acknowledge dispatch handshake towards the CPU.
module interrupt_controller
    import interrupt_defs::*;
#(
    parameter int NUM_IRQ = 5
) (
    input  logic       iClock,
    input  logic       iReset_n,
    input  logic       iIrqVblank,
    input  logic       iIrqLcdStat,
    input  logic       iIrqTimer,
    input  logic       iIrqSerial,
    input  logic       iIrqJoypad,
    input  logic       iMcuWe,
    input  logic [3:0] iMcuRegSelect,
    input  logic       iMcuIeWe,
    input  logic [7:0] iMcuWriteData,
    input  logic       iEof,
    input  logic       iEi,
    input  logic       iDi,
    input  logic       iReti,
    input  logic       iIrqAck,
    output logic [7:0] oIf,
    output logic [7:0] oIe,
    output logic       oIme,
    output logic       oIrqRequest,
    output logic [7:0] oIrqVector,
    output logic       oWakeUp
);

    logic [NUM_IRQ-1:0] ifReg;
    logic [NUM_IRQ-1:0] ifNext;
    logic [NUM_IRQ-1:0] pulses;
    logic [NUM_IRQ-1:0] ackClear;
    logic [7:0]         ieReg;
    logic               ime;
    logic               imeNext;
    logic               ifWrite;

    eiState_t  eiState;
    eiState_t  eiNext;
    irqState_t irqState;
    irqState_t irqNext;
    logic      startDispatch;

    logic [2:0] winIndex;
    logic       winValid;
    logic [7:0] winVector;
    logic [2:0] latchIndex;
    logic [7:0] latchVector;

    interrupt_priority_encoder uEncoder (
        .pending (ifReg & ieReg[NUM_IRQ-1:0]),
        .index   (winIndex),
        .valid   (winValid),
        .vector  (winVector)
    );

    always_comb begin
        pulses                  = '0;
        pulses[IRQ_BIT_VBLANK]  = iIrqVblank;
        pulses[IRQ_BIT_LCDSTAT] = iIrqLcdStat;
        pulses[IRQ_BIT_TIMER]   = iIrqTimer;
        pulses[IRQ_BIT_SERIAL]  = iIrqSerial;
        pulses[IRQ_BIT_JOYPAD]  = iIrqJoypad;
    end

    // Hardware pulses are OR-ed in last so they win over both an MCU write
    // and the post-dispatch clear of the same bit.
    always_comb begin
        ifWrite  = iMcuWe && (iMcuRegSelect == IF_REG_SEL);
        ackClear = '0;
        if (irqState == IRQ_ACK) begin
            ackClear = NUM_IRQ'(1) << latchIndex;
        end
        ifNext = ifWrite ? iMcuWriteData[NUM_IRQ-1:0] : (ifReg & ~ackClear);
        ifNext = ifNext | pulses;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            ifReg       <= '0;
            ieReg       <= '0;
            ime         <= 1'b0;
            latchIndex  <= '0;
            latchVector <= '0;
        end else begin
            ifReg <= ifNext;
            ime   <= imeNext;
            if (iMcuIeWe) begin
                ieReg <= iMcuWriteData;
            end
            if (startDispatch) begin
                latchIndex  <= winIndex;
                latchVector <= winVector;
            end
        end
    end

    // EI sub-FSM
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            eiState <= EI_IDLE;
        end else begin
            eiState <= eiNext;
        end
    end

    // An EI whose end-of-instruction strobe arrives with it skips EI_ARM, so
    // IME still rises only at the end of the instruction after EI.
    always_comb begin
        eiNext  = eiState;
        imeNext = ime;
        if (irqState == IRQ_ACK || iDi) begin
            eiNext  = EI_IDLE;
            imeNext = 1'b0;
        end else begin
            case (eiState)
                EI_IDLE:  if (iEi) eiNext = iEof ? EI_DELAY : EI_ARM;
                EI_ARM:   if (iEof) eiNext = EI_DELAY;
                EI_DELAY: begin
                    if (iEof) begin
                        eiNext  = EI_IDLE;
                        imeNext = 1'b1;
                    end
                end
                default:  eiNext = EI_IDLE;
            endcase
            if (iReti) begin
                imeNext = 1'b1;
            end
        end
    end

    // Dispatch FSM
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            irqState <= IRQ_IDLE;
        end else begin
            irqState <= irqNext;
        end
    end

    always_comb begin
        irqNext       = irqState;
        startDispatch = 1'b0;
        case (irqState)
            IRQ_IDLE: begin
                if (iEof && ime && winValid) begin
                    irqNext       = IRQ_REQ;
                    startDispatch = 1'b1;
                end
            end
            IRQ_REQ:  if (iIrqAck) irqNext = IRQ_ACK;
            IRQ_ACK:  irqNext = IRQ_IDLE;
            default:  irqNext = IRQ_IDLE;
        endcase
    end

    always_comb begin
        oIf         = {3'b111, ifReg};
        oIe         = ieReg;
        oIme        = ime;
        oIrqRequest = (irqState == IRQ_REQ);
        oIrqVector  = (irqState == IRQ_REQ) ? latchVector : 8'h00;
        oWakeUp     = |(ifReg & ieReg[NUM_IRQ-1:0]);
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a register/wake-up vector table
// followed by hand-written dispatch, EI/DI and reset sequences.
module tb_interrupt_controller;

    logic       iClock = 1'b0;
    logic       iReset_n = 1'b0;
    logic       iIrqVblank = 1'b0;
    logic       iIrqLcdStat = 1'b0;
    logic       iIrqTimer = 1'b0;
    logic       iIrqSerial = 1'b0;
    logic       iIrqJoypad = 1'b0;
    logic       iMcuWe = 1'b0;
    logic [3:0] iMcuRegSelect = 4'h0;
    logic       iMcuIeWe = 1'b0;
    logic [7:0] iMcuWriteData = 8'h00;
    logic       iEof = 1'b0;
    logic       iEi = 1'b0;
    logic       iDi = 1'b0;
    logic       iReti = 1'b0;
    logic       iIrqAck = 1'b0;
    logic [7:0] oIf;
    logic [7:0] oIe;
    logic       oIme;
    logic       oIrqRequest;
    logic [7:0] oIrqVector;
    logic       oWakeUp;

    int checks = 0;
    int errors = 0;

    interrupt_controller #(.NUM_IRQ(5)) dut (
        .iClock        (iClock),
        .iReset_n      (iReset_n),
        .iIrqVblank    (iIrqVblank),
        .iIrqLcdStat   (iIrqLcdStat),
        .iIrqTimer     (iIrqTimer),
        .iIrqSerial    (iIrqSerial),
        .iIrqJoypad    (iIrqJoypad),
        .iMcuWe        (iMcuWe),
        .iMcuRegSelect (iMcuRegSelect),
        .iMcuIeWe      (iMcuIeWe),
        .iMcuWriteData (iMcuWriteData),
        .iEof          (iEof),
        .iEi           (iEi),
        .iDi           (iDi),
        .iReti         (iReti),
        .iIrqAck       (iIrqAck),
        .oIf           (oIf),
        .oIe           (oIe),
        .oIme          (oIme),
        .oIrqRequest   (oIrqRequest),
        .oIrqVector    (oIrqVector),
        .oWakeUp       (oWakeUp)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [7:0] ie;
        logic       doIfWrite;
        logic [7:0] ifData;
        logic [4:0] pulses;
        logic [7:0] expIf;
        logic       expWake;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge iClock);
    endtask

    task automatic doReset();
        iReset_n = 1'b0;
        tick();
        tick();
        iReset_n = 1'b1;
        tick();
    endtask

    task automatic setPulses(input logic [4:0] p);
        {iIrqJoypad, iIrqSerial, iIrqTimer, iIrqLcdStat, iIrqVblank} = p;
    endtask

    task automatic writeIe(input logic [7:0] d);
        iMcuIeWe = 1'b1;
        iMcuWriteData = d;
        tick();
        iMcuIeWe = 1'b0;
    endtask

    task automatic writeIf(input logic [7:0] d);
        iMcuWe = 1'b1;
        iMcuRegSelect = 4'hF;
        iMcuWriteData = d;
        tick();
        iMcuWe = 1'b0;
    endtask

    task automatic pulse(input logic [4:0] p);
        setPulses(p);
        tick();
        setPulses(5'b0);
    endtask

    task automatic eof();
        iEof = 1'b1;
        tick();
        iEof = 1'b0;
    endtask

    task automatic reti();
        iReti = 1'b1;
        tick();
        iReti = 1'b0;
    endtask

    task automatic ack();
        iIrqAck = 1'b1;
        tick();
        iIrqAck = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{ie: 8'h00, doIfWrite: 1'b1, ifData: 8'h00, pulses: 5'b00000, expIf: 8'hE0, expWake: 1'b0};
        vecs[1] = '{ie: 8'h04, doIfWrite: 1'b0, ifData: 8'h00, pulses: 5'b00100, expIf: 8'hE4, expWake: 1'b1};
        vecs[2] = '{ie: 8'h01, doIfWrite: 1'b0, ifData: 8'h00, pulses: 5'b00000, expIf: 8'hE4, expWake: 1'b0};
        vecs[3] = '{ie: 8'h01, doIfWrite: 1'b1, ifData: 8'h00, pulses: 5'b01000, expIf: 8'hE8, expWake: 1'b0};
        vecs[4] = '{ie: 8'h08, doIfWrite: 1'b1, ifData: 8'h1F, pulses: 5'b00000, expIf: 8'hFF, expWake: 1'b1};
        vecs[5] = '{ie: 8'hE0, doIfWrite: 1'b1, ifData: 8'h00, pulses: 5'b00000, expIf: 8'hE0, expWake: 1'b0};
        vecs[6] = '{ie: 8'h10, doIfWrite: 1'b1, ifData: 8'h00, pulses: 5'b10000, expIf: 8'hF0, expWake: 1'b1};
        vecs[7] = '{ie: 8'h1F, doIfWrite: 1'b1, ifData: 8'h00, pulses: 5'b11111, expIf: 8'hFF, expWake: 1'b1};
        vecs[8] = '{ie: 8'h00, doIfWrite: 1'b1, ifData: 8'h15, pulses: 5'b00000, expIf: 8'hF5, expWake: 1'b0};
        vecs[9] = '{ie: 8'h02, doIfWrite: 1'b1, ifData: 8'hFF, pulses: 5'b00000, expIf: 8'hFF, expWake: 1'b1};

        // Reset state
        iReset_n = 1'b0;
        tick();
        check("rst_if", oIf, 8'hE0);
        check("rst_ie", oIe, 8'h00);
        check("rst_ime", {7'b0, oIme}, 8'h00);
        check("rst_req", {7'b0, oIrqRequest}, 8'h00);
        check("rst_vec", oIrqVector, 8'h00);
        check("rst_wake", {7'b0, oWakeUp}, 8'h00);
        doReset();

        // Register / wake-up table (IME stays 0, so no request may appear)
        for (int i = 0; i < 10; i++) begin
            writeIe(vecs[i].ie);
            iMcuWe = vecs[i].doIfWrite;
            iMcuRegSelect = 4'hF;
            iMcuWriteData = vecs[i].ifData;
            setPulses(vecs[i].pulses);
            tick();
            iMcuWe = 1'b0;
            setPulses(5'b0);
            check($sformatf("vec%0d_if", i), oIf, vecs[i].expIf);
            check($sformatf("vec%0d_ie", i), oIe, vecs[i].ie);
            check($sformatf("vec%0d_wake", i), {7'b0, oWakeUp}, {7'b0, vecs[i].expWake});
            check($sformatf("vec%0d_req", i), {7'b0, oIrqRequest}, 8'h00);
        end

        // Timer dispatch with request held through IE changes
        doReset();
        writeIe(8'h04);
        reti();
        check("tmr_ime", {7'b0, oIme}, 8'h01);
        pulse(5'b00100);
        check("tmr_if", oIf, 8'hE4);
        eof();
        check("tmr_req", {7'b0, oIrqRequest}, 8'h01);
        check("tmr_vec", oIrqVector, 8'h50);
        writeIe(8'h00);
        tick();
        check("tmr_hold_req", {7'b0, oIrqRequest}, 8'h01);
        check("tmr_hold_vec", oIrqVector, 8'h50);
        writeIe(8'h04);
        ack();
        check("tmr_ack_req", {7'b0, oIrqRequest}, 8'h00);
        check("tmr_ack_vec", oIrqVector, 8'h00);
        check("tmr_ack_if", oIf, 8'hE4);
        tick();
        check("tmr_done_if", oIf, 8'hE0);
        check("tmr_done_ime", {7'b0, oIme}, 8'h00);

        // Priority: VBlank first, then LCD STAT
        writeIf(8'h1F);
        writeIe(8'h1F);
        reti();
        eof();
        check("pri_vec0", oIrqVector, 8'h40);
        ack();
        tick();
        check("pri_if0", oIf, 8'hFE);
        check("pri_ime0", {7'b0, oIme}, 8'h00);
        reti();
        eof();
        check("pri_vec1", oIrqVector, 8'h48);
        ack();
        tick();
        check("pri_if1", oIf, 8'hFC);

        // Pulse on the latched bit during the ack cycle wins over the clear
        reti();
        eof();
        check("race_vec", oIrqVector, 8'h50);
        ack();
        pulse(5'b00100);
        check("race_if", oIf, 8'hFC);
        check("race_ime", {7'b0, oIme}, 8'h00);

        // EI delay: EI together with its end strobe
        doReset();
        writeIe(8'h01);
        writeIf(8'h01);
        iEi = 1'b1;
        iEof = 1'b1;
        tick();
        iEi = 1'b0;
        iEof = 1'b0;
        check("ei_req0", {7'b0, oIrqRequest}, 8'h00);
        check("ei_ime0", {7'b0, oIme}, 8'h00);
        eof();
        check("ei_ime1", {7'b0, oIme}, 8'h01);
        check("ei_req1", {7'b0, oIrqRequest}, 8'h00);
        eof();
        check("ei_req2", {7'b0, oIrqRequest}, 8'h01);
        check("ei_vec2", oIrqVector, 8'h40);
        ack();
        tick();

        // DI cancels a pending EI
        doReset();
        writeIe(8'h01);
        writeIf(8'h01);
        iEi = 1'b1;
        iEof = 1'b1;
        tick();
        iEi = 1'b0;
        iEof = 1'b0;
        iDi = 1'b1;
        tick();
        iDi = 1'b0;
        eof();
        eof();
        check("di_ime", {7'b0, oIme}, 8'h00);
        check("di_req", {7'b0, oIrqRequest}, 8'h00);

        // Multi-cycle EI: EI_ARM waits for the EI end strobe
        iEi = 1'b1;
        tick();
        iEi = 1'b0;
        tick();
        eof();
        check("arm_ime0", {7'b0, oIme}, 8'h00);
        eof();
        check("arm_ime1", {7'b0, oIme}, 8'h01);
        check("arm_req1", {7'b0, oIrqRequest}, 8'h00);
        eof();
        check("arm_req2", {7'b0, oIrqRequest}, 8'h01);

        // HALT wake-up with IME off, then async reset mid-request
        doReset();
        writeIe(8'h10);
        pulse(5'b10000);
        check("halt_wake", {7'b0, oWakeUp}, 8'h01);
        check("halt_req", {7'b0, oIrqRequest}, 8'h00);
        check("halt_if", oIf, 8'hF0);
        reti();
        eof();
        check("halt_vec", oIrqVector, 8'h60);
        #2;
        iReset_n = 1'b0;
        #1;
        check("arst_if", oIf, 8'hE0);
        check("arst_ie", oIe, 8'h00);
        check("arst_ime", {7'b0, oIme}, 8'h00);
        check("arst_req", {7'b0, oIrqRequest}, 8'h00);
        check("arst_vec", oIrqVector, 8'h00);
        check("arst_wake", {7'b0, oWakeUp}, 8'h00);
        tick();
        iReset_n = 1'b1;
        tick();
        check("post_rst_req", {7'b0, oIrqRequest}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Game Boy interrupt controller. It sits directly downstream of the timers block and consumes its `oInterrupt0x50` pulse, along with the VBlank, LCD STAT, serial and joypad request pulses. It holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME master enable, including the delayed enable after EI. At instruction boundaries it arbitrates pending interrupts by fixed priority and hands a vector to the CPU through a request/acknowledge handshake.

## Interface
Parameters:
- `NUM_IRQ`, 5, number of interrupt sources. Fixed at 5 for DMG; the parameter is for documentation only.

Ports:
- `iClock`  in  1  system clock; all state is updated on the posedge.
- `iReset_n`  in  1  reset, asynchronous, active-low.
- `iIrqVblank`, `iIrqLcdStat`, `iIrqTimer`, `iIrqSerial`, `iIrqJoypad`  in  1 each  one-cycle request pulses. `iIrqTimer` connects to timers `oInterrupt0x50`.
- `iMcuWe`  in  1  MCU write strobe for the 0xFF0x I/O page.
- `iMcuRegSelect`  in  4  low nibble of the I/O address; 4'hF selects IF.
- `iMcuIeWe`  in  1  write strobe for 0xFFFF (IE).
- `iMcuWriteData`  in  8  write data.
- `iEof`  in  1  end-of-instruction strobe from the CPU.
- `iEi`, `iDi`, `iReti`  in  1 each  decoded EI / DI / RETI, asserted during that instruction.
- `iIrqAck`  in  1  CPU has started dispatch.
- `oIf`  out  8  `{3'b111, IF[4:0]}`.
- `oIe`  out  8  IE register.
- `oIme`  out  1  master enable.
- `oIrqRequest`  out  1  dispatch request to the CPU.
- `oIrqVector`  out  8  dispatch address.
- `oWakeUp`  out  1  `|(IF & IE)`, independent of IME; used for HALT exit.

## Operation
- **IF bits:** 0 VBlank (0x40), 1 LCD STAT (0x48), 2 Timer (0x50), 3 Serial (0x58), 4 Joypad (0x60).
- **Setting IF:** a request pulse sets its IF bit on the next edge.
- **Writing IF:** an MCU write with `iMcuWe & iMcuRegSelect==4'hF` loads `IF <= data[4:0]`. If a hardware pulse lands in the same cycle, that bit ends up 1 (set wins).
- **Writing IE:** `iMcuIeWe` loads all 8 bits of IE. Bits [7:5] are stored but do not take part in arbitration.
- **Arbitration:** among `IF & IE`, the lowest set bit wins. The vector is `8'h40 + 8*index`.
- **IME sub-FSM (states `EI_IDLE`, `EI_ARM`, `EI_DELAY`):**
  - `iEi` in `EI_IDLE` moves to `EI_ARM`.
  - `EI_ARM` moves to `EI_DELAY` on `iEof` (end of the EI instruction).
  - `EI_DELAY` sets IME and returns to `EI_IDLE` on the next `iEof` (end of the following instruction).
  - `iDi` clears IME and forces `EI_IDLE` on the next edge; it overrides a pending EI.
  - `iReti` sets IME on the next edge.
  - EI issued while IME is already 1 has no visible effect.
- **Dispatch FSM (states `IRQ_IDLE`, `IRQ_REQ`, `IRQ_ACK`):**
  - `IRQ_IDLE` moves to `IRQ_REQ` when `iEof & IME & |(IF&IE[4:0])`. On that transition the winning index and its vector are latched.
  - `IRQ_REQ` drives `oIrqRequest=1` and the latched `oIrqVector`. It holds until `iIrqAck`, even if IF, IE or IME change meanwhile.
  - On `iIrqAck`, the FSM moves to `IRQ_ACK`.
  - `IRQ_ACK` lasts one cycle. It clears the latched IF bit, clears IME, forces `EI_IDLE`, then returns to `IRQ_IDLE`.
  - If the latched IF bit is set again by a pulse in the `IRQ_ACK` cycle, the set wins.
- **Idle outputs:** in states other than `IRQ_REQ`, `oIrqVector` outputs 8'h00.

## Timing
- Reset (async assert, sync release): IF=0, IE=0, IME=0, both FSMs in their IDLE state. Outputs: `oIf`=8'hE0, `oIe`=0, `oIme`=0, `oIrqRequest`=0, `oIrqVector`=0, `oWakeUp`=0.
- Request pulse at edge N: IF bit visible at N+1. `oWakeUp` is combinational from registers, so it is also high at N+1.
- Request raised by an `iEof` sampled at edge N: `oIrqRequest` is high from N+1.
- Ack sampled at edge M: `oIrqRequest` drops at M+1, and the IF bit clears and IME=0 at M+2.
- Reset asserted mid-dispatch: outputs return to reset values immediately.
- All outputs are registered except `oWakeUp`.

## Structure
- **Shared package (`interrupt_defs`):** IF bit indices, vector constants 8'h40 through 8'h60, IF register index 4'hF, and the `IRQ_*` and `EI_*` state encodings.
- **Sub-module `interrupt_priority_encoder`:** combinational 5-bit lowest-set-bit encoder producing a 3-bit index, a valid flag and the 8-bit vector.

## Test plan
- **Timer pulse:** reset; IE=8'h04, IME set via RETI; pulse `iIrqTimer`; `iEof` → `oIrqRequest`=1, `oIrqVector`=8'h50. Ack → IF=8'hE0, IME=0.
- **Priority:** IF=8'h1F, IE=8'h1F, IME=1, `iEof` → vector 8'h40. After ack → IF=8'hFE. The next `iEof` (with IME restored) → vector 8'h48.
- **EI delay:** IME=0, IF/IE bit 0 set. Assert `iEi` with `iEof` → no request. At the next `iEof` IME becomes 1 but no request is issued that cycle. At the following `iEof` → request with vector 8'h40.
- **DI cancels EI:** assert `iEi`+`iEof`, then `iDi` before the next `iEof` → IME stays 0 and no request is raised.
- **Write/set race:** MCU writes IF=8'h00 in the same cycle as `iIrqSerial` → `oIf`=8'hE8.
- **HALT wake and async reset:** IME=0, IE=8'h10, pulse `iIrqJoypad` → `oWakeUp`=1, `oIrqRequest`=0. Then drive `iReset_n` low mid-cycle while `IRQ_REQ` is active → all outputs return to reset values without waiting for a clock edge.
